// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings and defaults for the fetch/data memory arbiter.
package mem_arb_pkg;
    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;
    localparam int TCW = 8;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_IBUSY = 2'd1;
    localparam logic [1:0] S_DBUSY = 2'd2;
    typedef enum logic [1:0] {
        IDLE = S_IDLE,
        IBUSY = S_IBUSY,
        DBUSY = S_DBUSY
    } state_e;
endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: counts busy cycles without MemReady and flags when the limit is reached.
module mem_arb_timer
    import mem_arb_pkg::*;
#(
    parameter logic [TCW-1:0] TIMEOUT = 8'd255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    logic [TCW-1:0] cnt_q, cnt_d;
    assign expired_o = cnt_q == TIMEOUT;
    always_comb cnt_d = clr_i ? '0 : (en_i && !expired_o) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk_i) cnt_q <= rst_i ? '0 : cnt_d;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one variable-latency memory port between fetch and data requesters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int MAX_DBURST = 4,
    parameter int TIMEOUT = 255
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          IReq,
    input  logic [AW-1:0] IAddr,
    output logic [DW-1:0] IRData,
    output logic          IValid,
    input  logic          DReq,
    input  logic          DWE,
    input  logic [AW-1:0] DAddr,
    input  logic [DW-1:0] DWData,
    output logic [DW-1:0] DRData,
    output logic          DValid,
    output logic          MemReq,
    output logic          MemWE,
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemWData,
    input  logic [DW-1:0] MemRData,
    input  logic          MemReady,
    output logic          IWait,
    output logic          DWait,
    output logic          ErrTimeout
);
    localparam int BW = $clog2(MAX_DBURST + 1);
    localparam logic [BW-1:0] MAXB = BW'(MAX_DBURST);
    state_e state_q, state_d;
    logic mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic ivalid_q, ivalid_d, dvalid_q, dvalid_d, err_q, err_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d, irdata_q, irdata_d, drdata_q, drdata_d;
    logic [BW-1:0] burst_q, burst_d;
    logic i_el, d_el, gnt_i, gnt_d, busy, expired, done;
    logic [DW-1:0] rdata;
    // A requester whose Valid is high this cycle is being retired, not re-granted.
    assign i_el = IReq && !ivalid_q;
    assign d_el = DReq && !dvalid_q;
    assign gnt_d = d_el && !(i_el && burst_q == MAXB);
    assign gnt_i = i_el && !gnt_d;
    assign busy = state_q != IDLE;
    assign done = busy && (MemReady || expired);
    assign rdata = MemReady ? MemRData : '0;
    mem_arb_timer #(.TIMEOUT(TCW'(TIMEOUT))) u_timer (
        .clk_i    (CLK),
        .rst_i    (Reset),
        .clr_i    (!busy),
        .en_i     (busy && !MemReady),
        .expired_o(expired)
    );
    always_comb begin
        state_d = state_q;
        mem_req_d = mem_req_q;
        mem_we_d = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        irdata_d = irdata_q;
        drdata_d = drdata_q;
        burst_d = burst_q;
        err_d = err_q;
        ivalid_d = 1'b0;
        dvalid_d = 1'b0;
        if (!busy && (gnt_i || gnt_d)) begin
            state_d = gnt_d ? DBUSY : IBUSY;
            mem_req_d = 1'b1;
            mem_we_d = gnt_d && DWE;
            mem_addr_d = gnt_d ? DAddr : IAddr;
            mem_wdata_d = gnt_d ? DWData : mem_wdata_q;
            burst_d = (gnt_d && IReq) ? (burst_q == MAXB ? burst_q : burst_q + 1'b1) : '0;
        end else if (done) begin
            state_d = IDLE;
            mem_req_d = 1'b0;
            err_d = err_q || !MemReady;
            ivalid_d = state_q == IBUSY;
            dvalid_d = state_q == DBUSY;
            irdata_d = state_q == IBUSY ? rdata : irdata_q;
            drdata_d = (state_q == DBUSY && !mem_we_q) ? rdata : drdata_q;
        end
    end
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= IDLE;
            mem_req_q <= 1'b0;
            mem_we_q <= 1'b0;
            mem_addr_q <= '0;
            mem_wdata_q <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
            burst_q <= '0;
            err_q <= 1'b0;
            ivalid_q <= 1'b0;
            dvalid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mem_req_q <= mem_req_d;
            mem_we_q <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
            burst_q <= burst_d;
            err_q <= err_d;
            ivalid_q <= ivalid_d;
            dvalid_q <= dvalid_d;
        end
    end
    assign MemReq = mem_req_q;
    assign MemWE = mem_we_q;
    assign MemAddr = mem_addr_q;
    assign MemWData = mem_wdata_q;
    assign IRData = irdata_q;
    assign DRData = drdata_q;
    assign IValid = ivalid_q;
    assign DValid = dvalid_q;
    assign ErrTimeout = err_q;
    assign IWait = IReq && !ivalid_q;
    assign DWait = DReq && !dvalid_q;
endmodule
